// File: rtl/acc_drain_if.sv
// Host-side bundle for acc_drain: drain control, accumulator snapshot source,
// DRAM write port and status. The master modport is the host, the slave modport is the engine.
interface acc_drain_if #(
  parameter int ACC_WIDTH      = 32,
  parameter int ARRAY_DIM      = 16,
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_ADDR_WIDTH = 2,
  parameter int STREAM_WIDTH   = 32
);
  // start and resume are level requests with no ready or acknowledge.
  // start is taken on any rising clock edge where the engine is idle.
  // resume is taken on any rising clock edge where the engine is paused.
  // At all other times both are ignored.
  // wen is a write strobe with no back-pressure. The RAM must accept waddr/dout on every cycle that wen is high.
  logic                                     start;
  logic                                     resume;
  logic [ARRAY_DIM-1:0]                     pe_en_up;
  logic [ARRAY_DIM-1:0]                     pe_en_left;
  logic [RAM_ADDR_WIDTH-1:0]                start_waddr;
  logic [ARRAY_DIM*ARRAY_DIM*ACC_WIDTH-1:0] acc;
  logic                                     wen;
  logic [RAM_ADDR_WIDTH-1:0]                waddr;
  logic [RAM_WIDTH-1:0]                     dout;
  logic                                     started;
  logic                                     pause;
  logic                                     done;
  logic [STREAM_WIDTH-1:0]                  count;
  logic [1:0]                               dbg_state;

  modport master (
    output start, resume, pe_en_up, pe_en_left, start_waddr, acc,
    input  wen, waddr, dout, started, pause, done, count, dbg_state
  );

  modport slave (
    input  start, resume, pe_en_up, pe_en_left, start_waddr, acc,
    output wen, waddr, dout, started, pause, done, count, dbg_state
  );
endinterface

// File: rtl/acc_drain.sv
// Snapshots the systolic accumulators on start and writes the active region row-major into
// RAM_DEPTH-word DRAM windows, pausing for resume between windows. Define ACC_DRAIN_RELU_EN to clamp negative words to 0.
module acc_drain #(
  parameter int ACC_WIDTH      = 32,
  parameter int ARRAY_DIM      = 16,
  parameter int DIM_WIDTH      = 4,
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_DEPTH      = 4,
  parameter int RAM_ADDR_WIDTH = 2,
  parameter int STREAM_WIDTH   = 32
) (
  input  logic         clk,
  input  logic         reset,
  acc_drain_if.slave   bus
);
  localparam int CNT_W = DIM_WIDTH + 1;
  localparam int WIN_W = $clog2(RAM_DEPTH + 1);
  localparam int N_EL  = ARRAY_DIM * ARRAY_DIM;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PAUSE, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0]      r_snap [N_EL];
  logic [CNT_W-1:0]          r_rows, r_cols, r_row, r_col;
  logic [CNT_W-1:0]          w_rows_nxt, w_cols_nxt, w_row_nxt, w_col_nxt;
  logic [CNT_W-1:0]          w_rows_pc, w_cols_pc;
  logic [RAM_ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [WIN_W-1:0]          r_win, w_win_nxt;
  logic                      w_snap_load;

  logic                      r_wen, w_wen_nxt;
  logic [RAM_ADDR_WIDTH-1:0] r_waddr, w_waddr_nxt;
  logic [RAM_WIDTH-1:0]      r_dout, w_dout_nxt;
  logic                      r_started, w_started_nxt;
  logic                      r_pause, w_pause_nxt;
  logic                      r_done, w_done_nxt;
  logic [STREAM_WIDTH-1:0]   r_count, w_count_nxt;

  logic [2*DIM_WIDTH-1:0]    w_idx;
  logic [ACC_WIDTH-1:0]      w_elem;
  logic [RAM_WIDTH-1:0]      w_elem_ext;
  logic                      w_row_last, w_col_last;

  // Enable masks are thermometer codes, so the popcount is the active extent.
  always_comb begin
    w_rows_pc = '0;
    w_cols_pc = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      w_rows_pc = w_rows_pc + CNT_W'(bus.pe_en_left[i]);
      w_cols_pc = w_cols_pc + CNT_W'(bus.pe_en_up[i]);
    end
  end

  assign w_idx      = {r_row[DIM_WIDTH-1:0], r_col[DIM_WIDTH-1:0]};
  assign w_elem     = r_snap[w_idx];
  assign w_row_last = (r_row == r_rows - CNT_W'(1));
  assign w_col_last = (r_col == r_cols - CNT_W'(1));

`ifdef ACC_DRAIN_RELU_EN
  assign w_elem_ext = w_elem[ACC_WIDTH-1] ? '0 : RAM_WIDTH'(signed'(w_elem));
`else
  assign w_elem_ext = RAM_WIDTH'(signed'(w_elem));
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_rows_nxt    = r_rows;
    w_cols_nxt    = r_cols;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_base_nxt    = r_base;
    w_win_nxt     = r_win;
    w_snap_load   = 1'b0;
    w_wen_nxt     = 1'b0;
    w_waddr_nxt   = r_waddr;
    w_dout_nxt    = r_dout;
    w_started_nxt = 1'b0;
    w_pause_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_count_nxt   = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_snap_load = 1'b1;
          w_rows_nxt  = w_rows_pc;
          w_cols_nxt  = w_cols_pc;
          w_base_nxt  = bus.start_waddr;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_win_nxt   = '0;
          w_count_nxt = '0;
          w_state_nxt = (w_rows_pc == '0 || w_cols_pc == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        w_wen_nxt     = 1'b1;
        w_waddr_nxt   = r_base + RAM_ADDR_WIDTH'(r_win);
        w_dout_nxt    = w_elem_ext;
        w_started_nxt = 1'b1;
        w_count_nxt   = r_count + STREAM_WIDTH'(1);
        w_win_nxt     = r_win + WIN_W'(1);
        // The final element ends the drain even if it also fills the window.
        if (w_row_last && w_col_last) begin
          w_state_nxt = S_DONE;
        end else begin
          if (w_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + CNT_W'(1);
          end else begin
            w_col_nxt = r_col + CNT_W'(1);
          end
          if (r_win == WIN_W'(RAM_DEPTH - 1)) w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        w_started_nxt = 1'b1;
        w_pause_nxt   = 1'b1;
        if (bus.resume) begin
          w_base_nxt  = bus.start_waddr;
          w_win_nxt   = '0;
          w_state_nxt = S_WRITE;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_cols    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_base    <= '0;
      r_win     <= '0;
      r_wen     <= 1'b0;
      r_waddr   <= '0;
      r_dout    <= '0;
      r_started <= 1'b0;
      r_pause   <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      for (int i = 0; i < N_EL; i++) r_snap[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rows    <= w_rows_nxt;
      r_cols    <= w_cols_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_base    <= w_base_nxt;
      r_win     <= w_win_nxt;
      r_wen     <= w_wen_nxt;
      r_waddr   <= w_waddr_nxt;
      r_dout    <= w_dout_nxt;
      r_started <= w_started_nxt;
      r_pause   <= w_pause_nxt;
      r_done    <= w_done_nxt;
      r_count   <= w_count_nxt;
      if (w_snap_load) begin
        for (int i = 0; i < N_EL; i++) r_snap[i] <= bus.acc[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  assign bus.wen       = r_wen;
  assign bus.waddr     = r_waddr;
  assign bus.dout      = r_dout;
  assign bus.started   = r_started;
  assign bus.pause     = r_pause;
  assign bus.done      = r_done;
  assign bus.count     = r_count;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: a table of drain scenarios with hand-computed write streams,
// plus a hand-written reset-mid-drain sequence.
module tb_acc_drain;
  localparam int ACC_WIDTH      = 32;
  localparam int ARRAY_DIM      = 16;
  localparam int DIM_WIDTH      = 4;
  localparam int RAM_WIDTH      = 32;
  localparam int RAM_DEPTH      = 4;
  localparam int RAM_ADDR_WIDTH = 2;
  localparam int STREAM_WIDTH   = 32;
  localparam int ACC_BITS       = ARRAY_DIM * ARRAY_DIM * ACC_WIDTH;
  localparam int SB_W           = RAM_ADDR_WIDTH + RAM_WIDTH;
  localparam int N_VEC          = 7;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  acc_drain_if #(
    .ACC_WIDTH(ACC_WIDTH), .ARRAY_DIM(ARRAY_DIM), .RAM_WIDTH(RAM_WIDTH),
    .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH), .STREAM_WIDTH(STREAM_WIDTH)
  ) bus ();

  acc_drain #(
    .ACC_WIDTH(ACC_WIDTH), .ARRAY_DIM(ARRAY_DIM), .DIM_WIDTH(DIM_WIDTH),
    .RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
    .STREAM_WIDTH(STREAM_WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [ARRAY_DIM-1:0]      en_left;
    logic [ARRAY_DIM-1:0]      en_up;
    logic [RAM_ADDR_WIDTH-1:0] waddr0;
    logic [RAM_ADDR_WIDTH-1:0] waddr_res;
    bit                        neg;
    int                        n_words;
    int                        n_pause;
    int                        done_cyc;
    logic [RAM_WIDTH-1:0]      exp_data [9];
    logic [RAM_ADDR_WIDTH-1:0] exp_addr [9];
  } vec_t;

  vec_t            vecs [N_VEC];
  logic [SB_W-1:0] exp_q [$];
  int              n_pass = 0;
  int              n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // acc(r,c) = r*16+c; optionally (0,0) = -10 and (0,1) = 5.
  function automatic logic [ACC_BITS-1:0] make_acc(input bit neg);
    logic [ACC_BITS-1:0] a;
    a = '0;
    for (int r = 0; r < ARRAY_DIM; r++)
      for (int c = 0; c < ARRAY_DIM; c++)
        a[(r*ARRAY_DIM+c)*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(r*16 + c);
    if (neg) begin
      a[0 +: ACC_WIDTH]         = 32'hFFFF_FFF6;
      a[ACC_WIDTH +: ACC_WIDTH] = 32'd5;
    end
    return a;
  endfunction

  task automatic fill_table();
    logic [RAM_WIDTH-1:0] neg_word;
`ifdef ACC_DRAIN_RELU_EN
    neg_word = 32'h0;
`else
    neg_word = 32'hFFFF_FFF6;
`endif
    vecs[0] = '{16'h0007, 16'h0007, 2'd0, 2'd0, 1'b0, 9, 2, 14,
                '{32'd0, 32'd1, 32'd2, 32'd16, 32'd17, 32'd18, 32'd32, 32'd33, 32'd34},
                '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0}};
    vecs[1] = '{16'h0003, 16'h0003, 2'd0, 2'd0, 1'b0, 4, 0, 5,
                '{32'd0, 32'd1, 32'd16, 32'd17, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[2] = '{16'h0007, 16'h0007, 2'd2, 2'd1, 1'b0, 9, 2, 14,
                '{32'd0, 32'd1, 32'd2, 32'd16, 32'd17, 32'd18, 32'd32, 32'd33, 32'd34},
                '{2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1}};
    vecs[3] = '{16'h0001, 16'h0003, 2'd0, 2'd0, 1'b1, 2, 0, 3,
                '{neg_word, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[4] = '{16'h0000, 16'h000F, 2'd1, 2'd0, 1'b0, 0, 0, 1,
                '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[5] = '{16'h000F, 16'h0001, 2'd0, 2'd0, 1'b0, 4, 0, 5,
                '{32'd0, 32'd16, 32'd32, 32'd48, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[6] = '{16'h0001, 16'h001F, 2'd3, 2'd2, 1'b0, 5, 1, 8,
                '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0},
                '{2'd3, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0}};
  endtask

  // Launch a drain, answer each pause with a one-cycle resume, score every write.
  // abort_cyc > 0 returns mid-drain at that cycle after start.
  task automatic run_vec(input int i, input int abort_cyc);
    int          cyc;
    int          pauses;
    bit          prev_pause;
    bit          seen_done;
    logic [SB_W-1:0] exp;
    @(negedge clk);
    bus.pe_en_left  = vecs[i].en_left;
    bus.pe_en_up    = vecs[i].en_up;
    bus.start_waddr = vecs[i].waddr0;
    bus.acc         = make_acc(vecs[i].neg);
    bus.start       = 1'b1;
    for (int k = 0; k < vecs[i].n_words; k++)
      exp_q.push_back({vecs[i].exp_addr[k], vecs[i].exp_data[k]});
    @(negedge clk);
    bus.start       = 1'b0;
    bus.start_waddr = vecs[i].waddr_res;
    bus.acc         = ~bus.acc;
    check($sformatf("v%0d_no_write_at_accept", i), {bus.started, bus.wen}, 2'b00);
    cyc = 0; pauses = 0; prev_pause = 1'b0; seen_done = 1'b0;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.start  = (cyc == 2);
      bus.resume = bus.pause && !prev_pause;
      if (bus.pause && !prev_pause) pauses++;
      prev_pause = bus.pause;
      if (cyc == 1 && vecs[i].n_words > 0)
        check($sformatf("v%0d_first_write_latency", i), {bus.started, bus.wen}, 2'b11);
      if (bus.wen) begin
        check($sformatf("v%0d_write_expected", i), (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check($sformatf("v%0d_write_addr_data", i), {bus.waddr, bus.dout}, exp);
        end
      end
      if (bus.done) begin
        seen_done = 1'b1;
        check($sformatf("v%0d_done_cycle", i), cyc, vecs[i].done_cyc);
        check($sformatf("v%0d_count", i), bus.count, vecs[i].n_words);
        check($sformatf("v%0d_started_low_at_done", i), {bus.started, bus.wen}, 2'b00);
        check($sformatf("v%0d_pauses", i), pauses, vecs[i].n_pause);
      end
      if (abort_cyc != 0 && cyc == abort_cyc) begin
        bus.start  = 1'b0;
        bus.resume = 1'b0;
        return;
      end
    end
    bus.start  = 1'b0;
    bus.resume = 1'b0;
    check($sformatf("v%0d_done_seen", i), seen_done, 1);
    check($sformatf("v%0d_queue_empty", i), exp_q.size(), 0);
    @(negedge clk);
    check($sformatf("v%0d_done_one_cycle", i), {bus.done, bus.dbg_state}, 3'b000);
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.resume      = 1'b0;
    bus.pe_en_up    = '0;
    bus.pe_en_left  = '0;
    bus.start_waddr = '0;
    bus.acc         = '0;
    fill_table();
    repeat (3) @(negedge clk);
    check("reset_wen", bus.wen, 0);
    check("reset_waddr", bus.waddr, 0);
    check("reset_dout", bus.dout, 0);
    check("reset_flags", {bus.started, bus.pause, bus.done}, 3'b000);
    check("reset_count", bus.count, 0);
    check("reset_state", bus.dbg_state, 0);
    reset = 1'b0;

    for (int i = 0; i < N_VEC; i++) run_vec(i, 0);

    // Reset in the second window, then a clean re-drain from (0,0).
    run_vec(0, 8);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_wen", bus.wen, 0);
    check("midreset_waddr", bus.waddr, 0);
    check("midreset_dout", bus.dout, 0);
    check("midreset_flags", {bus.started, bus.pause, bus.done}, 3'b000);
    check("midreset_count", bus.count, 0);
    check("midreset_state", bus.dbg_state, 0);
    reset = 1'b0;
    exp_q.delete();
    run_vec(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
